// File: rtl/cipu_job_sched.sv
// Job scheduler between a host byte port and one CIPU: buffers a people stream,
// a thing stream and pop counts, launches CIPU, paces pops and tags results.
module cipu_job_sched #(
  parameter int DEPTH   = 32,
  parameter int NUMQ    = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_valid,
  input  logic [1:0] host_sel,
  input  logic [7:0] host_data,
  input  logic       host_flush,
  output logic       host_ready,
  output logic       ready_fifo,
  output logic       ready_lifo,
  output logic [7:0] people_thing_in,
  output logic [7:0] thing_in,
  output logic [3:0] thing_num,
  input  logic       valid_fifo,
  input  logic       valid_lifo,
  input  logic       valid_fifo2,
  input  logic [7:0] people_thing_out,
  input  logic [7:0] thing_out,
  input  logic       done_thing,
  input  logic       done_lifo,
  input  logic       done_fifo,
  input  logic       done_fifo2,
  output logic       res_valid,
  output logic [1:0] res_tag,
  output logic [7:0] res_data,
  output logic       job_done,
  output logic       err,
  output logic [2:0] dbg_state
);

  localparam int AW = $clog2(DEPTH) + 1;
  localparam int IW = AW - 1;
  localparam int QW = $clog2(NUMQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] DEPTH_V = AW'(DEPTH);
  localparam logic [QW:0]   NUMQ_V  = (QW + 1)'(NUMQ);
  localparam logic [WW-1:0] TO_M1   = WW'(TIMEOUT - 1);
  localparam logic [7:0]    DOLLAR  = 8'h24;
  localparam logic [7:0]    SEMI    = 8'h3B;

  typedef enum logic [2:0] {
    S_LOAD     = 3'd0,
    S_LAUNCH   = 3'd1,
    S_STREAM   = 3'd2,
    S_WAIT_POP = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   p_wr_q, p_wr_d, t_wr_q, t_wr_d;
  logic [AW-1:0]   p_rd_q, p_rd_d, t_rd_q, t_rd_d;
  logic            p_closed_q, p_closed_d, t_closed_q, t_closed_d;
  logic [QW-1:0]   q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [QW:0]     q_cnt_q, q_cnt_d;
  logic            p_run_q, p_run_d;
  logic [7:0]      pt_in_q, pt_in_d, t_in_q, t_in_d;
  logic [3:0]      t_num_q, t_num_d;
  logic            rdy_q, rdy_d;
  logic            seen_f_q, seen_f_d, seen_f2_q, seen_f2_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            res_v_q, res_v_d;
  logic [1:0]      res_tag_q, res_tag_d;
  logic [7:0]      res_data_q, res_data_d;
  logic            skid_v_q, skid_v_d;
  logic [1:0]      skid_tag_q, skid_tag_d;
  logic [7:0]      skid_data_q, skid_data_d;
  logic            job_done_q, job_done_d, err_q, err_d;

  logic [7:0] people_mem [DEPTH];
  logic [7:0] thing_mem  [DEPTH];
  logic [3:0] q_mem      [NUMQ];

  logic       p_full, t_full, q_full, wr_acc, t_load, clear_job, cipu_act, th_req;
  logic [1:0] th_tag;
  logic [7:0] cur_p, cur_t;

  assign p_full   = (p_wr_q == DEPTH_V);
  assign t_full   = (t_wr_q == DEPTH_V);
  assign q_full   = (q_cnt_q == NUMQ_V);
  assign cur_p    = people_mem[p_rd_q[IW-1:0]];
  assign cur_t    = thing_mem[t_rd_q[IW-1:0]];
  assign cipu_act = valid_fifo | valid_lifo | valid_fifo2 |
                    done_thing | done_lifo | done_fifo | done_fifo2;

  // Host handshake: a byte transfers on any rising edge where host_valid and
  // host_ready are both high; host_ready never depends on host_valid.
  always_comb begin
    host_ready = 1'b0;
    if (rst_n && state_q == S_LOAD && !host_flush) begin
      case (host_sel)
        2'd0:    host_ready = !p_closed_q && !p_full;
        2'd1:    host_ready = !t_closed_q && !t_full;
        2'd2:    host_ready = !q_full;
        default: host_ready = 1'b0;
      endcase
    end
  end
  assign wr_acc = host_valid && host_ready;

  always_ff @(posedge clk) begin
    if (wr_acc && host_sel == 2'd0) people_mem[p_wr_q[IW-1:0]] <= host_data;
    if (wr_acc && host_sel == 2'd1) thing_mem[t_wr_q[IW-1:0]]  <= host_data;
    if (wr_acc && host_sel == 2'd2) q_mem[q_wr_q]              <= host_data[3:0];
  end

  always_comb begin
    state_d     = state_q;
    p_wr_d      = p_wr_q;
    t_wr_d      = t_wr_q;
    p_rd_d      = p_rd_q;
    t_rd_d      = t_rd_q;
    p_closed_d  = p_closed_q;
    t_closed_d  = t_closed_q;
    q_wr_d      = q_wr_q;
    q_rd_d      = q_rd_q;
    q_cnt_d     = q_cnt_q;
    p_run_d     = p_run_q;
    pt_in_d     = 8'h00;
    t_in_d      = 8'h00;
    t_num_d     = t_num_q;
    seen_f_d    = seen_f_q;
    seen_f2_d   = seen_f2_q;
    wd_d        = wd_q;
    res_v_d     = 1'b0;
    res_tag_d   = res_tag_q;
    res_data_d  = res_data_q;
    skid_v_d    = skid_v_q;
    skid_tag_d  = skid_tag_q;
    skid_data_d = skid_data_q;
    rdy_d       = 1'b0;
    job_done_d  = 1'b0;
    err_d       = 1'b0;
    t_load      = 1'b0;
    clear_job   = 1'b0;
    th_req      = valid_lifo | valid_fifo2;
    th_tag      = valid_lifo ? 2'd1 : 2'd2;

    case (state_q)
      S_LOAD: begin
        if (host_flush) begin
          clear_job = 1'b1;
        end else if (wr_acc) begin
          case (host_sel)
            2'd0: begin
              p_wr_d = p_wr_q + 1'b1;
              if (host_data == DOLLAR) p_closed_d = 1'b1;
            end
            2'd1: begin
              t_wr_d = t_wr_q + 1'b1;
              if (host_data == DOLLAR) t_closed_d = 1'b1;
            end
            2'd2: begin
              q_wr_d  = q_wr_q + 1'b1;
              q_cnt_d = q_cnt_q + 1'b1;
            end
            default: ;
          endcase
        end
        if (!host_flush && p_closed_d && t_closed_d) state_d = S_LAUNCH;
      end
      S_LAUNCH, S_STREAM: t_load = 1'b1;
      S_WAIT_POP:         t_load = done_thing;
      S_DRAIN:            if (seen_f_q && seen_f2_q) state_d = S_DONE;
      S_DONE: begin
        state_d   = S_LOAD;
        clear_job = 1'b1;
      end
      default: state_d = S_LOAD;
    endcase

    // The state follows the byte being placed on thing_in, so a pop starts
    // in the same cycle its ';' becomes visible.
    if (t_load) begin
      t_in_d = cur_t;
      t_rd_d = t_rd_q + 1'b1;
      if (cur_t == SEMI) begin
        state_d = S_WAIT_POP;
        if (q_cnt_q != '0) begin
          t_num_d = q_mem[q_rd_q];
          q_rd_d  = q_rd_q + 1'b1;
          q_cnt_d = q_cnt_q - 1'b1;
        end else begin
          t_num_d = 4'd0;
        end
      end else if (cur_t == DOLLAR) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_STREAM;
      end
    end

    if (state_q == S_LAUNCH || p_run_q) begin
      pt_in_d = cur_p;
      p_rd_d  = p_rd_q + 1'b1;
      p_run_d = (cur_p != DOLLAR);
    end

    if (state_q inside {S_LAUNCH, S_STREAM, S_WAIT_POP, S_DRAIN}) begin
      if (done_fifo)  seen_f_d  = 1'b1;
      if (done_fifo2) seen_f2_d = 1'b1;
    end

    if (state_q == S_LOAD || state_q == S_LAUNCH || cipu_act) begin
      wd_d = '0;
    end else if (wd_q == TO_M1) begin
      wd_d      = '0;
      err_d     = 1'b1;
      clear_job = 1'b1;
      state_d   = S_LOAD;
    end else begin
      wd_d = wd_q + 1'b1;
    end

    if (clear_job) begin
      p_wr_d     = '0;
      t_wr_d     = '0;
      p_rd_d     = '0;
      t_rd_d     = '0;
      p_closed_d = 1'b0;
      t_closed_d = 1'b0;
      q_wr_d     = '0;
      q_rd_d     = '0;
      q_cnt_d    = '0;
      p_run_d    = 1'b0;
      seen_f_d   = 1'b0;
      seen_f2_d  = 1'b0;
      pt_in_d    = 8'h00;
      t_in_d     = 8'h00;
    end

    // A thing result colliding with fifo waits one cycle in the skid slot,
    // which then outranks fresh lifo/fifo2 strobes.
    if (valid_fifo) begin
      res_v_d    = 1'b1;
      res_tag_d  = 2'd0;
      res_data_d = people_thing_out;
      if (!skid_v_q && th_req) begin
        skid_v_d    = 1'b1;
        skid_tag_d  = th_tag;
        skid_data_d = thing_out;
      end
    end else if (skid_v_q) begin
      res_v_d     = 1'b1;
      res_tag_d   = skid_tag_q;
      res_data_d  = skid_data_q;
      skid_v_d    = th_req;
      skid_tag_d  = th_tag;
      skid_data_d = thing_out;
    end else if (th_req) begin
      res_v_d    = 1'b1;
      res_tag_d  = th_tag;
      res_data_d = thing_out;
    end

    rdy_d      = (state_d == S_LAUNCH);
    job_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      p_wr_q      <= '0;
      t_wr_q      <= '0;
      p_rd_q      <= '0;
      t_rd_q      <= '0;
      p_closed_q  <= 1'b0;
      t_closed_q  <= 1'b0;
      q_wr_q      <= '0;
      q_rd_q      <= '0;
      q_cnt_q     <= '0;
      p_run_q     <= 1'b0;
      pt_in_q     <= 8'h00;
      t_in_q      <= 8'h00;
      t_num_q     <= 4'd0;
      rdy_q       <= 1'b0;
      seen_f_q    <= 1'b0;
      seen_f2_q   <= 1'b0;
      wd_q        <= '0;
      res_v_q     <= 1'b0;
      res_tag_q   <= 2'd0;
      res_data_q  <= 8'h00;
      skid_v_q    <= 1'b0;
      skid_tag_q  <= 2'd0;
      skid_data_q <= 8'h00;
      job_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_wr_q      <= p_wr_d;
      t_wr_q      <= t_wr_d;
      p_rd_q      <= p_rd_d;
      t_rd_q      <= t_rd_d;
      p_closed_q  <= p_closed_d;
      t_closed_q  <= t_closed_d;
      q_wr_q      <= q_wr_d;
      q_rd_q      <= q_rd_d;
      q_cnt_q     <= q_cnt_d;
      p_run_q     <= p_run_d;
      pt_in_q     <= pt_in_d;
      t_in_q      <= t_in_d;
      t_num_q     <= t_num_d;
      rdy_q       <= rdy_d;
      seen_f_q    <= seen_f_d;
      seen_f2_q   <= seen_f2_d;
      wd_q        <= wd_d;
      res_v_q     <= res_v_d;
      res_tag_q   <= res_tag_d;
      res_data_q  <= res_data_d;
      skid_v_q    <= skid_v_d;
      skid_tag_q  <= skid_tag_d;
      skid_data_q <= skid_data_d;
      job_done_q  <= job_done_d;
      err_q       <= err_d;
    end
  end

  assign ready_fifo      = rdy_q;
  assign ready_lifo      = rdy_q;
  assign people_thing_in = pt_in_q;
  assign thing_in        = t_in_q;
  assign thing_num       = t_num_q;
  assign res_valid       = res_v_q;
  assign res_tag         = res_tag_q;
  assign res_data        = res_data_q;
  assign job_done        = job_done_q;
  assign err             = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_cipu_job_sched.sv
// Directed bench for cipu_job_sched: job flow, pops, forwarding/skid,
// backpressure on a small instance, watchdog and asynchronous reset.
module tb_cipu_job_sched;

  localparam int TIMEOUT = 1023;
  localparam logic [2:0] ST_LOAD = 3'd0, ST_LAUNCH = 3'd1, ST_STREAM = 3'd2,
                         ST_WAIT = 3'd3, ST_DRAIN = 3'd4, ST_DONE = 3'd5;

  logic clk, rst_n;
  logic host_valid, host_flush, host_ready;
  logic [1:0] host_sel;
  logic [7:0] host_data;
  logic ready_fifo, ready_lifo;
  logic [7:0] people_thing_in, thing_in;
  logic [3:0] thing_num;
  logic valid_fifo, valid_lifo, valid_fifo2;
  logic [7:0] people_thing_out, thing_out;
  logic done_thing, done_lifo, done_fifo, done_fifo2;
  logic res_valid, job_done, err;
  logic [1:0] res_tag;
  logic [7:0] res_data;
  logic [2:0] dbg_state;

  logic s_host_valid, s_host_flush, s_host_ready;
  logic [1:0] s_host_sel;
  logic [7:0] s_host_data;
  logic s_ready_fifo, s_ready_lifo, s_res_valid, s_job_done, s_err;
  logic [7:0] s_people_thing_in, s_thing_in, s_res_data;
  logic [3:0] s_thing_num;
  logic [1:0] s_res_tag;
  logic [2:0] s_dbg_state;
  logic       zero1;
  logic [7:0] zero8;

  int n_checks, n_fail, k;
  logic jd_seen;

  cipu_job_sched #(.DEPTH(32), .NUMQ(8), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .host_valid(host_valid), .host_sel(host_sel), .host_data(host_data),
    .host_flush(host_flush), .host_ready(host_ready),
    .ready_fifo(ready_fifo), .ready_lifo(ready_lifo),
    .people_thing_in(people_thing_in), .thing_in(thing_in), .thing_num(thing_num),
    .valid_fifo(valid_fifo), .valid_lifo(valid_lifo), .valid_fifo2(valid_fifo2),
    .people_thing_out(people_thing_out), .thing_out(thing_out),
    .done_thing(done_thing), .done_lifo(done_lifo), .done_fifo(done_fifo),
    .done_fifo2(done_fifo2),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
    .job_done(job_done), .err(err), .dbg_state(dbg_state)
  );

  cipu_job_sched #(.DEPTH(4), .NUMQ(2), .TIMEOUT(TIMEOUT)) u_small (
    .clk(clk), .rst_n(rst_n),
    .host_valid(s_host_valid), .host_sel(s_host_sel), .host_data(s_host_data),
    .host_flush(s_host_flush), .host_ready(s_host_ready),
    .ready_fifo(s_ready_fifo), .ready_lifo(s_ready_lifo),
    .people_thing_in(s_people_thing_in), .thing_in(s_thing_in), .thing_num(s_thing_num),
    .valid_fifo(zero1), .valid_lifo(zero1), .valid_fifo2(zero1),
    .people_thing_out(zero8), .thing_out(zero8),
    .done_thing(zero1), .done_lifo(zero1), .done_fifo(zero1), .done_fifo2(zero1),
    .res_valid(s_res_valid), .res_tag(s_res_tag), .res_data(s_res_data),
    .job_done(s_job_done), .err(s_err), .dbg_state(s_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    host_valid = 1'b1; host_sel = sel; host_data = d;
    #1;
    chk("host_ready_wr", host_ready, 1);
    step();
    host_valid = 1'b0;
  endtask

  task automatic s_wr(input logic [1:0] sel, input logic [7:0] d);
    s_host_valid = 1'b1; s_host_sel = sel; s_host_data = d;
    #1;
    chk("s_host_ready_wr", s_host_ready, 1);
    step();
    s_host_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] pt, input logic [7:0] t,
                         input logic [2:0] st);
    chk({tag, "_people"}, people_thing_in, pt);
    chk({tag, "_thing"}, thing_in, t);
    chk({tag, "_state"}, dbg_state, st);
  endtask

  task automatic fwd(input string tag, input logic vf, input logic vl, input logic vf2,
                     input logic [7:0] d, input logic [1:0] etag);
    valid_fifo = vf; valid_lifo = vl; valid_fifo2 = vf2;
    people_thing_out = d; thing_out = d;
    step();
    valid_fifo = 1'b0; valid_lifo = 1'b0; valid_fifo2 = 1'b0;
    chk({tag, "_valid"}, res_valid, 1);
    chk({tag, "_tag"}, res_tag, etag);
    chk({tag, "_data"}, res_data, d);
  endtask

  task automatic both_done();
    done_fifo = 1'b1; done_fifo2 = 1'b1;
    step();
    done_fifo = 1'b0; done_fifo2 = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; jd_seen = 1'b0;
    zero1 = 1'b0; zero8 = 8'h00;
    rst_n = 1'b1;
    host_valid = 0; host_sel = 0; host_data = 0; host_flush = 0;
    valid_fifo = 0; valid_lifo = 0; valid_fifo2 = 0;
    people_thing_out = 0; thing_out = 0;
    done_thing = 0; done_lifo = 0; done_fifo = 0; done_fifo2 = 0;
    s_host_valid = 0; s_host_sel = 0; s_host_data = 0; s_host_flush = 0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_host_ready", host_ready, 0);
    chk("rst_ready_fifo", ready_fifo, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_thing_num", thing_num, 0);
    chk("rst_state", dbg_state, ST_LOAD);
    #10 rst_n = 1'b1;
    step();
    chk("post_rst_host_ready", host_ready, 1);

    // Backpressure on a DEPTH=4 / NUMQ=2 instance
    s_wr(0, 8'h41); s_wr(0, 8'h42); s_wr(0, 8'h43); s_wr(0, 8'h24);
    s_host_sel = 2'd0; #1;
    chk("bp_closed_full_sel0", s_host_ready, 0);
    s_wr(1, 8'h31); s_wr(1, 8'h32); s_wr(1, 8'h33); s_wr(1, 8'h34);
    s_host_sel = 2'd1; #1;
    chk("bp_full_sel1", s_host_ready, 0);
    chk("bp_still_load", s_dbg_state, ST_LOAD);
    s_host_sel = 2'd3; s_host_valid = 1'b1; #1;
    chk("bp_sel3", s_host_ready, 0);
    step(); s_host_valid = 1'b0;
    s_wr(2, 8'h01); s_wr(2, 8'h02);
    s_host_sel = 2'd2; #1;
    chk("bp_q_full", s_host_ready, 0);
    s_host_flush = 1'b1;
    step();
    s_host_flush = 1'b0; s_host_sel = 2'd0; #1;
    chk("bp_flush_sel0", s_host_ready, 1);
    s_host_sel = 2'd2; #1;
    chk("bp_flush_sel2", s_host_ready, 1);
    step();

    // Basic job: people "AB1C$", things "12;3$", counts {1}
    wr(2, 8'h01);
    wr(0, 8'h41); wr(0, 8'h42); wr(0, 8'h31); wr(0, 8'h43); wr(0, 8'h24);
    wr(1, 8'h31); wr(1, 8'h32); wr(1, 8'h3B); wr(1, 8'h33); wr(1, 8'h24);
    chk("b_ready_fifo", ready_fifo, 1);
    chk("b_ready_lifo", ready_lifo, 1);
    chk("b_launch", dbg_state, ST_LAUNCH);
    step(); chk_out("b1", 8'h41, 8'h31, ST_STREAM);
    chk("b_ready_off", ready_fifo, 0);
    step(); chk_out("b2", 8'h42, 8'h32, ST_STREAM);
    step(); chk_out("b3", 8'h31, 8'h3B, ST_WAIT);
    chk("b_thing_num", thing_num, 1);
    step(); chk_out("b4", 8'h43, 8'h00, ST_WAIT);
    step(); chk_out("b5", 8'h24, 8'h00, ST_WAIT);
    step(); chk_out("b6", 8'h00, 8'h00, ST_WAIT);
    done_thing = 1'b1;
    step(); done_thing = 1'b0;
    chk_out("b7", 8'h00, 8'h33, ST_STREAM);
    step(); chk_out("b8", 8'h00, 8'h24, ST_DRAIN);
    step(); chk_out("b9", 8'h00, 8'h00, ST_DRAIN);
    fwd("b_rA", 1, 0, 0, 8'h41, 2'd0);
    fwd("b_rB", 1, 0, 0, 8'h42, 2'd0);
    fwd("b_rC", 1, 0, 0, 8'h43, 2'd0);
    fwd("b_r2", 0, 1, 0, 8'h32, 2'd1);
    fwd("b_r1", 0, 0, 1, 8'h31, 2'd2);
    fwd("b_r3", 0, 0, 1, 8'h33, 2'd2);
    step(); chk("b_res_idle", res_valid, 0);
    done_fifo = 1'b1; step(); done_fifo = 1'b0;
    chk("b_jd_early1", job_done, 0);
    done_fifo2 = 1'b1; step(); done_fifo2 = 1'b0;
    chk("b_jd_early2", job_done, 0);
    step(); chk("b_job_done", job_done, 1);
    chk("b_state_done", dbg_state, ST_DONE);
    step(); chk("b_job_done_off", job_done, 0);
    chk("b_back_load", dbg_state, ST_LOAD);
    chk("b_num_hold", thing_num, 1);

    // Skid: fifo and lifo together, in LOAD after the job
    valid_fifo = 1'b1; valid_lifo = 1'b1; people_thing_out = 8'h58; thing_out = 8'h59;
    step(); valid_fifo = 1'b0; valid_lifo = 1'b0;
    chk("skid_first_tag", res_tag, 0);
    chk("skid_first_data", res_data, 8'h58);
    step();
    chk("skid_second_valid", res_valid, 1);
    chk("skid_second_tag", res_tag, 1);
    chk("skid_second_data", res_data, 8'h59);
    step(); chk("skid_idle", res_valid, 0);

    // Empty count queue: things "7;$"
    wr(0, 8'h24); wr(1, 8'h37); wr(1, 8'h3B); wr(1, 8'h24);
    chk("e_ready", ready_lifo, 1);
    step(); chk_out("e1", 8'h24, 8'h37, ST_STREAM);
    step(); chk_out("e2", 8'h00, 8'h3B, ST_WAIT);
    chk("e_thing_num", thing_num, 0);
    done_thing = 1'b1; step(); done_thing = 1'b0;
    chk_out("e3", 8'h00, 8'h24, ST_DRAIN);
    both_done();
    chk("e_jd_early", job_done, 0);
    step(); chk("e_job_done", job_done, 1);
    step(); chk("e_job_done_off", job_done, 0);

    // Zero pop: counts {0}, things "5;6$"
    wr(2, 8'h00); wr(0, 8'h24);
    wr(1, 8'h35); wr(1, 8'h3B); wr(1, 8'h36); wr(1, 8'h24);
    step(); chk_out("z1", 8'h24, 8'h35, ST_STREAM);
    step(); chk_out("z2", 8'h00, 8'h3B, ST_WAIT);
    chk("z_thing_num", thing_num, 0);
    done_thing = 1'b1; step(); done_thing = 1'b0;
    chk_out("z3", 8'h00, 8'h36, ST_STREAM);
    step(); chk_out("z4", 8'h00, 8'h24, ST_DRAIN);
    fwd("z_r0", 0, 1, 0, 8'h30, 2'd1);
    fwd("z_r5", 0, 0, 1, 8'h35, 2'd2);
    fwd("z_r6", 0, 0, 1, 8'h36, 2'd2);
    both_done();
    step(); chk("z_job_done", job_done, 1);
    step();

    // Asynchronous reset in WAIT_POP with a skidded result pending
    wr(2, 8'h02); wr(0, 8'h51); wr(0, 8'h24);
    wr(1, 8'h31); wr(1, 8'h3B); wr(1, 8'h32); wr(1, 8'h24);
    step(); step();
    chk("r_wait", dbg_state, ST_WAIT);
    chk("r_thing_num", thing_num, 2);
    valid_fifo = 1'b1; valid_lifo = 1'b1; people_thing_out = 8'h46; thing_out = 8'h4C;
    step(); valid_fifo = 1'b0; valid_lifo = 1'b0;
    chk("r_fifo_out", res_data, 8'h46);
    rst_n = 1'b0;
    #1;
    chk("r_res_valid", res_valid, 0);
    chk("r_res_data", res_data, 0);
    chk("r_thing_num0", thing_num, 0);
    chk("r_people_in", people_thing_in, 0);
    chk("r_state", dbg_state, ST_LOAD);
    chk("r_host_ready", host_ready, 0);
    #4 rst_n = 1'b1;
    step();
    chk("r_no_stale_res", res_valid, 0);
    chk("r_no_stale_ready", ready_fifo, 0);
    wr(0, 8'h5A); wr(0, 8'h24); wr(1, 8'h34); wr(1, 8'h24);
    chk("r2_ready", ready_fifo, 1);
    step(); chk_out("r2_1", 8'h5A, 8'h34, ST_STREAM);
    step(); chk_out("r2_2", 8'h24, 8'h24, ST_DRAIN);
    both_done();
    step(); chk("r2_job_done", job_done, 1);
    step();

    // Watchdog: done_fifo2 withheld
    wr(0, 8'h24); wr(1, 8'h24);
    step(); chk("w_drain", dbg_state, ST_DRAIN);
    done_fifo = 1'b1; step(); done_fifo = 1'b0;
    k = 0;
    while (k < 1100 && err !== 1'b1) begin
      step();
      k++;
      if (job_done === 1'b1) jd_seen = 1'b1;
    end
    chk("w_err_cycles", k, TIMEOUT);
    chk("w_no_job_done", jd_seen, 0);
    chk("w_state_load", dbg_state, ST_LOAD);
    host_sel = 2'd0; #1;
    chk("w_host_ready", host_ready, 1);
    step(); chk("w_err_pulse", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
